posit_add_scheduler: RTL and testbench

POSIT_ADD_SCHEDULER -- requirements
Module: posit_add_scheduler

---
 rtl/posit_add_scheduler.sv | 113 +++++++++++
 tb/tb_posit_add_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/posit_add_scheduler.sv
// Two-port arbiter in front of one shared posit adder datapath: grants one
// operand pair at a time, bypasses NaR/zero operands and returns the sum.
module posit_add_scheduler #(
  parameter int N   = 8,
  parameter int ES  = 3,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         req1_ready,
  output logic [N-1:0] dp_in1,
  output logic [N-1:0] dp_in2,
  input  logic [N-1:0] dp_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int           CW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  // ES only configures the external adder; reject shapes it cannot represent.
  if (LAT < 1 || ES >= N) begin : g_param_check
    $error("posit_add_scheduler: requires LAT >= 1 and ES < N");
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          ptr;
  logic          grant1;
  logic          accept;
  logic [N-1:0]  sel_a;
  logic [N-1:0]  sel_b;

  // NOTE: every signal driven here is assigned on every path, so no latch is
  // inferred; ready is also masked by reset so nothing reads as accepted then.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || ptr);
    req0_ready = (state == S_IDLE) && !reset && req0_valid && !grant1;
    req1_ready = (state == S_IDLE) && !reset && grant1;
    accept     = req0_ready || req1_ready;
    sel_a      = grant1 ? req1_a : req0_a;
    sel_b      = grant1 ? req1_b : req0_b;
  end

  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ptr        <= 1'b0;
      dp_in1     <= '0;
      dp_in2     <= '0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            dp_in1 <= sel_a;
            dp_in2 <= sel_b;
            rsp_id <= grant1;
            ptr    <= ~grant1;
            if (sel_a == NAR || sel_b == NAR) begin
              rsp_result <= NAR;
              state      <= S_DONE;
            end else if (sel_a == '0) begin
              rsp_result <= sel_b;
              state      <= S_DONE;
            end else if (sel_b == '0) begin
              rsp_result <= sel_a;
              state      <= S_DONE;
            end else begin
              cnt   <= CW'(LAT - 1);
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // dp_out is only trusted on the edge the countdown expires.
          if (cnt == '0) begin
            rsp_result <= dp_out;
            state      <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_add_scheduler.sv
// Randomised self-checking bench for posit_add_scheduler against a
// transaction-level model of grant order, bypass rules and latency.
module tb_posit_add_scheduler;

  localparam int N   = 8;
  localparam int ES  = 3;
  localparam int LAT = 2;
  localparam logic [N-1:0] NAR = 8'h80;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic [N-1:0] dp_in1, dp_in2, dp_out;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [N-1:0] rsp_result;

  int   checks = 0;
  int   errors = 0;
  logic exp_ptr;
  logic [N-1:0] last_dp;
  bit   dp_fix = 1'b0;

  posit_add_scheduler #(.N(N), .ES(ES), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .dp_in1     (dp_in1),
    .dp_in2     (dp_in2),
    .dp_out     (dp_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The datapath stand-in changes every cycle so a mistimed capture shows up.
  task automatic step();
    dp_out = dp_fix ? 8'h4A : N'($urandom);
    @(posedge clk);
    last_dp = dp_out;
    #1;
  endtask

  function automatic logic [N-1:0] rand_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return NAR;
    return N'($urandom);
  endfunction

  // One complete transaction: request, expected grant, latency, response
  // hold for 'hold' cycles with noise on the request ports, then handshake.
  task automatic serve(input bit v0, input bit v1,
                       input logic [N-1:0] a0, input logic [N-1:0] b0,
                       input logic [N-1:0] a1, input logic [N-1:0] b1,
                       input int hold);
    logic         g;
    logic [N-1:0] a, b, exp;
    bit           byp;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    g = (v0 && v1) ? exp_ptr : v1;
    check("ready0_grant", req0_ready, !g);
    check("ready1_grant", req1_ready, g);
    a = g ? a1 : a0;
    b = g ? b1 : b0;
    byp = 1'b1;
    if (a == NAR || b == NAR) exp = NAR;
    else if (a == '0)         exp = b;
    else if (b == '0)         exp = a;
    else begin
      byp = 1'b0;
      exp = '0;
    end
    step();
    exp_ptr = !g;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("dp_in1_latched", dp_in1, a);
    check("dp_in2_latched", dp_in2, b);
    if (!byp) begin
      for (int k = 0; k < LAT; k++) begin
        check("no_early_valid", rsp_valid, 1'b0);
        check("busy_in_busy", busy, 1'b1);
        check("dp_in1_stable", dp_in1, a);
        check("dp_in2_stable", dp_in2, b);
        check("ready_in_busy", {req0_ready, req1_ready}, 2'b00);
        step();
      end
      exp = last_dp;
    end
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_result", rsp_result, exp);
    check("rsp_id", rsp_id, g);
    for (int k = 0; k < hold; k++) begin
      req0_valid = 1'($urandom); req0_a = rand_op(); req0_b = rand_op();
      req1_valid = 1'($urandom); req1_a = rand_op(); req1_b = rand_op();
      #1;
      check("ready_in_done", {req0_ready, req1_ready}, 2'b00);
      step();
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_result", rsp_result, exp);
      check("hold_id", rsp_id, g);
    end
    req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h44;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    step();
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("idle_after_rsp", busy, 1'b0);
    check("valid_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h40; req0_b = 8'h3D;
    req1_valid = 1'b1; req1_a = 8'h12; req1_b = 8'h34;
    rsp_ready  = 1'b0;
    dp_out     = '0;
    #2;
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_dp_in1", dp_in1, 8'h00);
    check("rst_dp_in2", dp_in2, 8'h00);
    check("rst_result", rsp_result, 8'h00);
    check("rst_id", rsp_id, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    reset   = 1'b0;
    exp_ptr = 1'b0;

    // Round-robin from reset: port 0, port 1, port 0.
    serve(1, 1, 8'h21, 8'h13, 8'h31, 8'h17, 0);
    serve(1, 1, 8'h22, 8'h14, 8'h32, 8'h18, 0);
    serve(1, 1, 8'h23, 8'h15, 8'h33, 8'h19, 0);

    dp_fix = 1'b1;
    serve(1, 0, 8'h40, 8'h3D, 8'h00, 8'h00, 0);
    check("fixed_dp_result", rsp_result, 8'h4A);
    dp_fix = 1'b0;

    serve(0, 1, 8'h00, 8'h00, 8'h00, 8'h52, 0);
    serve(1, 0, 8'h80, 8'h40, 8'h00, 8'h00, 0);
    serve(1, 0, 8'h11, 8'h22, 8'h00, 8'h00, 5);
    serve(0, 1, 8'h00, 8'h00, 8'h5A, 8'h27, 0);

    // Abort an in-flight addition with reset.
    req0_valid = 1'b1; req0_a = 8'h45; req0_b = 8'h36;
    #1;
    check("abort_ready", req0_ready, !(1'b0) && (exp_ptr == exp_ptr));
    step();
    req0_valid = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", rsp_valid, 1'b0);
    check("abort_dp_in1", dp_in1, 8'h00);
    @(negedge clk);
    reset   = 1'b0;
    exp_ptr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("abort_no_rsp", rsp_valid, 1'b0);
    end
    serve(1, 1, 8'h46, 8'h37, 8'h56, 8'h29, 0);

    for (int t = 0; t < 40; t++) begin
      int sel;
      sel = $urandom_range(1, 3);
      serve(sel[0], sel[1], rand_op(), rand_op(), rand_op(), rand_op(),
            $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
